// File: rtl/mips_lite_multicycle.sv
// Multi-cycle MIPS-lite core sharing one req/ack memory port for fetch and data.
// Latency: R-type 4, lw 5, sw 4, beq 3, j/jal 2, jsp 3 cycles at zero wait; +1 per wait cycle per access.
// Backpressure: the request is held stable until mem_ack; the core simply stalls in its state until then.
// Ports: clk/rst_n; mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in;
//        pc = current instruction address, halted = absorbing fault state, instret = retired count.
module mips_lite_multicycle #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       LINK_REG = 31,
  parameter int unsigned       JSP_REG  = 28,
  parameter logic [5:0]        JSP_OP   = 6'h1E
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instret
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);
  localparam logic [4:0] JSP_IDX  = 5'(JSP_REG);

  state_t            state;
  logic [31:0]       rf [32];
  logic [31:0]       ir, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [ADDR_W-1:0] npc_q;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       rs_val, rt_val, jsp_val, jt32, off, ea, alu_c;
  logic [ADDR_W-1:0] npc_c, jtgt, beq_tgt;
  logic              funct_ok;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];

  // $0 reads as zero regardless of array contents.
  assign rs_val  = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val  = (rt == 5'd0) ? '0 : rf[rt];
  assign jsp_val = (JSP_IDX == 5'd0) ? '0 : rf[JSP_IDX];

  assign npc_c = pc + ADDR_W'(4);
  // Upper npc bits survive only when the address is wider than the 28-bit jump field.
  assign jt32  = {32'(npc_c) >> 28, 28'd0} | {4'd0, ir[25:0], 2'b00};
  assign jtgt  = jt32[ADDR_W-1:0];

  assign off     = imm_q << 2;
  assign beq_tgt = (a_q == b_q) ? (npc_q + off[ADDR_W-1:0]) : npc_q;
  assign ea      = a_q + imm_q;

  always_comb begin
    alu_c    = '0;
    funct_ok = 1'b1;
    case (funct)
      F_ADD:   alu_c = a_q + b_q;
      F_SUB:   alu_c = a_q - b_q;
      F_AND:   alu_c = a_q & b_q;
      F_OR:    alu_c = a_q | b_q;
      F_SLT:   alu_c = {31'd0, $signed(a_q) < $signed(b_q)};
      default: funct_ok = 1'b0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{ir[10:6], jt32, off, ea, jsp_val};

  // Every retiring transition also raises the next fetch request, so FETCH
  // completes in the same cycle as a zero-wait ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      instret   <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      npc_q     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rs_val;
          b_q   <= rt_val;
          imm_q <= {{16{ir[15]}}, ir[15:0]};
          npc_q <= npc_c;
          if (op == JSP_OP) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= jsp_val[ADDR_W-1:0];
            state    <= S_MEM;
          end else begin
            case (op)
              OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state <= S_EXEC;
              OP_J, OP_JAL: begin
                if (op == OP_JAL && LINK_IDX != 5'd0) rf[LINK_IDX] <= 32'(npc_c);
                pc       <= jtgt;
                instret  <= instret + 32'd1;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= jtgt;
                state    <= S_FETCH;
              end
              default: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
            endcase
          end
        end
        S_EXEC: begin
          if (op == OP_RTYPE) begin
            if (funct_ok) begin
              alu_q <= alu_c;
              state <= S_WB;
            end else begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
          end else if (op == OP_BEQ) begin
            pc       <= beq_tgt;
            instret  <= instret + 32'd1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= beq_tgt;
            state    <= S_FETCH;
          end else if (ea[1:0] != 2'b00) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_SW);
            mem_addr  <= ea[ADDR_W-1:0];
            mem_wdata <= b_q;
            state     <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op == JSP_OP) begin
              pc       <= mem_rdata[ADDR_W-1:0];
              instret  <= instret + 32'd1;
              mem_we   <= 1'b0;
              mem_addr <= mem_rdata[ADDR_W-1:0];
              state    <= S_FETCH;
            end else if (op == OP_SW) begin
              pc       <= npc_q;
              instret  <= instret + 32'd1;
              mem_we   <= 1'b0;
              mem_addr <= npc_q;
              state    <= S_FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          if (op == OP_LW) begin
            if (rt != 5'd0) rf[rt] <= mdr_q;
          end else if (rd != 5'd0) begin
            rf[rd] <= alu_q;
          end
          pc       <= npc_q;
          instret  <= instret + 32'd1;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= npc_q;
          state    <= S_FETCH;
        end
        default: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
          state   <= S_HALT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_lite_multicycle.sv
// Directed bench for mips_lite_multicycle: behavioural memory with programmable ack delay,
// hand-encoded programs per scenario, checks on registers, PC, instret, cycle counts and bus traffic.
module tb_mips_lite_multicycle;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata, instret;
  logic        halted;

  mips_lite_multicycle dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [1024];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          req_cnt = 0;
  int          wr_count = 0;
  int          stable_err = 0;
  logic [15:0] wr_addr = '0, lat_addr = '0;
  logic [31:0] wr_data = '0, lat_wdata = '0;
  logic        lat_we = 1'b0;

  // Memory responder: counts wait cycles per request, checks the request stays put while waiting.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        req_cnt++;
        if (wait_cnt == 0) begin
          lat_addr = mem_addr; lat_we = mem_we; lat_wdata = mem_wdata;
        end else if (mem_addr !== lat_addr || mem_we !== lat_we || (lat_we && mem_wdata !== lat_wdata)) begin
          stable_err++;
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            mem[mem_addr[11:2]] = mem_wdata;
            wr_count++; wr_addr = mem_addr; wr_data = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
          end
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = HALT_W;
    #1;
  endtask

  task automatic release_reset(input int delay);
    ack_delay = delay;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance edge by edge until instret reaches n; cyc = edges taken. Timeout counts as a failure.
  task automatic wait_instret(input logic [31:0] n, output int cyc);
    cyc = 0;
    while (instret !== n && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    if (instret !== n) begin
      errors++;
      $display("FAIL wait_instret: instret=%0d required %0d within 300 cycles", instret, n);
    end
  endtask

  task automatic wait_halt();
    int cyc;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_timeout: halted=%b required 1", halted); end
  endtask

  task automatic test_reset();
    hold_reset();
    checks++; if (pc !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h want 0000", pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL rst_instret: got %0d want 0", instret); end
    checks++; if (dut.rf[31] !== 32'h0) begin errors++; $display("FAIL rst_rf31: got %h want 0", dut.rf[31]); end
    release_reset(0);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rel_req_early: got %b want 0", mem_req); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL first_fetch: req=%b we=%b addr=%h want 1/0/0000", mem_req, mem_we, mem_addr);
    end
  endtask

  task automatic test_rtype();
    int cyc;
    hold_reset();
    mem[128] = 32'd5; mem[129] = 32'd7;
    mem[0] = enc_i(6'h23, 0, 1, 16'h0200);
    mem[1] = enc_i(6'h23, 0, 2, 16'h0204);
    mem[2] = enc_r(1, 2, 3, 6'h20);
    mem[3] = enc_r(2, 1, 4, 6'h2A);
    mem[4] = enc_r(1, 2, 0, 6'h20);
    mem[5] = enc_r(0, 1, 6, 6'h20);
    mem[6] = enc_r(1, 2, 7, 6'h22);
    release_reset(0);
    wait_instret(2, cyc);
    wait_instret(4, cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL rtype_cycles: got %0d want 8", cyc); end
    checks++; if (dut.rf[3] !== 32'h0000000C) begin errors++; $display("FAIL add_r3: got %h want 0000000c", dut.rf[3]); end
    checks++; if (dut.rf[4] !== 32'h0) begin errors++; $display("FAIL slt_r4: got %h want 0", dut.rf[4]); end
    wait_halt();
    checks++; if (dut.rf[0] !== 32'h0) begin errors++; $display("FAIL r0_write: got %h want 0", dut.rf[0]); end
    checks++; if (dut.rf[6] !== 32'd5) begin errors++; $display("FAIL r0_read: got %h want 5", dut.rf[6]); end
    checks++; if (dut.rf[7] !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_r7: got %h want fffffffe", dut.rf[7]); end
    checks++; if (instret !== 32'd7) begin errors++; $display("FAIL rtype_instret: got %0d want 7", instret); end
  endtask

  task automatic test_ldst_wait();
    int cyc;
    hold_reset();
    mem[128] = 32'd5; mem[129] = 32'd7;
    mem[0] = enc_i(6'h23, 0, 1, 16'h0200);
    mem[1] = enc_i(6'h23, 0, 2, 16'h0204);
    mem[2] = enc_r(1, 2, 3, 6'h20);
    mem[3] = enc_i(6'h2B, 0, 3, 16'h0008);
    mem[4] = enc_i(6'h23, 0, 5, 16'h0008);
    release_reset(3);
    wait_instret(3, cyc);
    wait_instret(4, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL sw_wait_cycles: got %0d want 10", cyc); end
    checks++; if (wr_count !== 1 || wr_addr !== 16'h0008 || wr_data !== 32'h0000000C) begin
      errors++; $display("FAIL sw_bus: count=%0d addr=%h data=%h want 1/0008/0000000c", wr_count, wr_addr, wr_data);
    end
    wait_instret(5, cyc);
    checks++; if (cyc !== 11) begin errors++; $display("FAIL lw_wait_cycles: got %0d want 11", cyc); end
    checks++; if (dut.rf[5] !== 32'h0000000C) begin errors++; $display("FAIL lw_r5: got %h want 0000000c", dut.rf[5]); end
    checks++; if (stable_err !== 0) begin errors++; $display("FAIL req_stable: changes=%0d want 0", stable_err); end
  endtask

  task automatic test_branch_jump();
    int cyc;
    hold_reset();
    mem[128] = 32'd5;
    mem[0] = enc_i(6'h23, 0, 1, 16'h0200);
    mem[1] = enc_i(6'h23, 0, 2, 16'h0200);
    mem[2] = enc_r(0, 0, 0, 6'h20);
    mem[3] = enc_r(0, 0, 0, 6'h20);
    mem[4] = enc_i(6'h04, 1, 2, 16'h0002);
    mem[7] = enc_j(6'h03, 26'h40);
    mem[64] = enc_i(6'h04, 1, 0, 16'h0010);
    release_reset(0);
    wait_instret(4, cyc);
    wait_instret(5, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL beq_cycles: got %0d want 3", cyc); end
    checks++; if (pc !== 16'h001C) begin errors++; $display("FAIL beq_taken_pc: got %h want 001c", pc); end
    wait_instret(6, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL jal_cycles: got %0d want 2", cyc); end
    checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL jal_pc: got %h want 0100", pc); end
    checks++; if (dut.rf[31] !== 32'h00000020) begin errors++; $display("FAIL jal_link: got %h want 00000020", dut.rf[31]); end
    wait_instret(7, cyc);
    checks++; if (pc !== 16'h0104) begin errors++; $display("FAIL beq_not_taken_pc: got %h want 0104", pc); end
    wait_halt();
    checks++; if (pc !== 16'h0104 || instret !== 32'd7) begin
      errors++; $display("FAIL bj_halt_state: pc=%h instret=%0d want 0104/7", pc, instret);
    end
  endtask

  task automatic test_jsp();
    int cyc;
    hold_reset();
    mem[132] = 32'h00000040;
    mem[16] = 32'h00000080;
    mem[0] = enc_i(6'h23, 0, 28, 16'h0210);
    mem[1] = enc_j(6'h1E, 26'h0);
    release_reset(0);
    wait_instret(1, cyc);
    wait_instret(2, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL jsp_cycles: got %0d want 3", cyc); end
    checks++; if (pc !== 16'h0080) begin errors++; $display("FAIL jsp_pc: got %h want 0080", pc); end
    wait_halt();
    checks++; if (instret !== 32'd2) begin errors++; $display("FAIL jsp_instret: got %0d want 2", instret); end
  endtask

  task automatic test_faults();
    logic [31:0] fault_w [3];
    int snap;
    fault_w[0] = HALT_W;
    fault_w[1] = enc_r(1, 2, 3, 6'h00);
    fault_w[2] = enc_i(6'h23, 0, 5, 16'h0006);
    for (int k = 0; k < 3; k++) begin
      hold_reset();
      mem[0] = fault_w[k];
      mem[1] = enc_r(0, 0, 1, 6'h20);
      release_reset(0);
      wait_halt();
      checks++; if (pc !== 16'h0 || instret !== 32'd0) begin
        errors++; $display("FAIL fault%0d_state: pc=%h instret=%0d want 0000/0", k, pc, instret);
      end
      snap = req_cnt;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (req_cnt !== snap || mem_req !== 1'b0 || pc !== 16'h0) begin
        errors++; $display("FAIL fault%0d_frozen: reqs=%0d (was %0d) req=%b pc=%h", k, req_cnt, snap, mem_req, pc);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc, snap;
    hold_reset();
    mem[0] = enc_i(6'h2B, 0, 0, 16'h0020);
    release_reset(5);
    cyc = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL midwr_write_seen: we=%b want 1", mem_we); end
    snap = wr_count;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc !== 16'h0) begin
      errors++; $display("FAIL midwr_async_drop: req=%b pc=%h want 0/0000", mem_req, pc);
    end
    mem[0] = HALT_W;
    ack_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (wr_count !== snap || halted !== 1'b1) begin
      errors++; $display("FAIL midwr_no_reissue: writes=%0d (was %0d) halted=%b", wr_count, snap, halted);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ldst_wait();
    test_branch_jump();
    test_jsp();
    test_faults();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_lite_multicycle.md
# mips_lite_multicycle

Parametrised multi-cycle successor to the single-cycle MIPS-lite core. It runs the same instruction subset, including `jal` and `jsp`, through a state machine that shares one external memory port for instructions and data. A req/ack handshake on that port tolerates variable memory latency. Adds an instruction counter, `$0` hard-wired to zero, and a halt state for illegal or misaligned operations.

## Interface
- `ADDR_W`, 16: byte-address width of PC and memory port; PC and address arithmetic wrap modulo 2^ADDR_W.
- `RESET_PC`, 0: PC value loaded on reset.
- `LINK_REG`, 31: register written with PC+4 by `jal`.
- `JSP_REG`, 28: register whose value addresses the `jsp` target word.
- `JSP_OP`, 6'h1E: opcode of `jsp`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`.
- `mem_addr` out ADDR_W: byte address, word aligned, big-endian word.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: completes the current request.
- `pc` out ADDR_W: address of the current instruction.
- `halted` out 1: core is in HALT.
- `instret` out 32: count of retired instructions, wraps.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. On `mem_ack`, latch IR and go to DECODE.
- DECODE: read `rs`/`rt` into A/B, sign-extend imm16, form `npc`=`pc`+4. Dispatch by opcode:
  - 0x00 (R-type): go to EXEC.
  - 0x23 `lw`, 0x2B `sw`, 0x04 `beq`: go to EXEC.
  - 0x02 `j`: `pc` ← {`npc`[ADDR_W-1:28] if ADDR_W>28, IR[25:0]<<2 truncated to ADDR_W}; retire; go to FETCH.
  - 0x03 `jal`: same PC update as `j`, and `reg[LINK_REG]` ← zero-extended `npc`; retire; go to FETCH.
  - `JSP_OP`: `mem_addr` ← `reg[JSP_REG]`; go to MEM (read).
  - Any other opcode: go to HALT.
- EXEC:
  - R-type funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed): result → ALUOut; go to WB. Other funct → HALT.
  - `lw`/`sw`: ALUOut = A + imm. If ALUOut[1:0]≠0 → HALT, else go to MEM.
  - `beq`: `pc` ← A==B ? `npc`+(imm<<2) : `npc`; retire; go to FETCH.
- MEM:
  - `lw`/`jsp`: read request; on ack latch MDR.
  - `sw`: write B to ALUOut; on ack retire and go to FETCH.
  - `jsp`: on ack, `pc` ← `mem_rdata`[ADDR_W-1:0]; retire; go to FETCH.
- WB:
  - R-type: `reg[rd]` ← ALUOut.
  - `lw`: `reg[rt]` ← MDR.
  - `pc` ← `npc`; retire; go to FETCH.
- `reg[0]` always reads 0; writes to it are discarded, including `jal` when LINK_REG=0.
- HALT is absorbing: no requests, `pc` frozen; exit only by reset.
- Retire means `instret`+1 in the same edge as the PC update. HALT-causing instructions do not retire.

## Timing
- Reset values:
  - `pc`=RESET_PC; `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `halted`=0, `instret`=0; all registers 0; state FETCH.
  - First request is asserted in the first cycle after `rst_n` rises.
- Handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable from assertion until the edge where `mem_ack`=1 is sampled.
  - `mem_req` deasserts the next cycle.
  - `mem_ack` while `mem_req`=0 is ignored.
  - Ack may arrive in the first request cycle (zero wait).
- Cycles per instruction at zero wait: R-type 4, `lw` 5, `sw` 4, `beq` 3, `j`/`jal` 2, `jsp` 3. Each wait cycle adds 1 per memory access.
- Reset mid-request drops `mem_req` asynchronously; a pending write must not be reissued.
- `halted` asserts the cycle after the offending decision edge.

## Test plan
- R-type: reg1=5, reg2=7. Run `add $3,$1,$2` then `slt $4,$2,$1` → reg3=0x0000000C, reg4=0, `instret`=2 after 8 cycles (zero wait).
- Load/store with wait states: ack delayed 3 cycles. Run `sw $3,8($0)` then `lw $5,8($0)` → write seen at addr 0x0008 with data 0x0000000C; reg5=0x0000000C; request fields stable across the wait cycles.
- Branch/jump at PC=0x0010: `beq` taken with imm=2 → `pc`=0x001C. `jal` to index 0x40 → `pc`=0x0100 and reg31=0x00000020 (with `jal` at 0x001C).
- `jsp`: reg28=0x0040, mem[0x0040]=0x00000080 → `pc`=0x0080 after 3 cycles; `instret`+1.
- Faults: opcode 0x3F, funct 0x00, and `lw` at address 0x0006 → each sets `halted`=1, `pc` frozen, no further `mem_req`, `instret` unchanged.
- Reset and `$0`: `add $0,$1,$2` leaves reg0=0. Assert `rst_n` low during a `sw` wait → `mem_req` drops immediately, `pc`=RESET_PC, no write is issued after release.
